// File: rtl/_skid_buf_if.sv
// ---------------------------------------------------------------------------
// | Module   : _skid_buf_if                                                  |
// | Brief    : valid/ready handshake bundle for the two-entry skid buffer    |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

interface _skid_buf_if #(
  parameter int n = `WORD_LENGTH
) ();
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_data;
  logic [1:0]   count;

  // master: the surrounding pipeline (producer + consumer); slave: the buffer
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

`default_nettype wire

// File: rtl/_skid_buf.sv
// ---------------------------------------------------------------------------
// | Module   : _skid_buf                                                     |
// | Brief    : two-entry elastic pipeline register, registered valid/ready   |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module _skid_buf #(
  parameter int n = `WORD_LENGTH
) (
  input  logic          clk,
  input  logic          rst_n,
  _skid_buf_if.slave    bus
);

  // State is simply the pair of valid bits {skid_v, main_v}
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic         r_main_v;
  logic         r_skid_v;
  logic [n-1:0] r_main_d;
  logic [n-1:0] r_skid_d;

  logic [1:0]   w_state;
  logic         w_in_fire;
  logic         w_out_fire;

  assign w_state    = {r_skid_v, r_main_v};
  assign w_in_fire  = bus.in_valid & ~r_skid_v;
  assign w_out_fire = r_main_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (bus.flush) begin
      // Data registers are left alone; they are don't-care while invalid
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      case (w_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main_v <= 1'b1;
            r_main_d <= bus.in_data;
          end
        end
        ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_skid_v <= 1'b1;
            r_skid_d <= bus.in_data;
          end else if (w_in_fire && w_out_fire) begin
            r_main_d <= bus.in_data;
          end else if (w_out_fire) begin
            r_main_v <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          // Skid valid without main valid cannot occur; recover to EMPTY
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_main_v;
  assign bus.out_data  = r_main_d;
  assign bus.in_ready  = ~r_skid_v;
  assign bus.count     = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

`default_nettype wire

// File: doc/_skid_buf.md
# _skid_buf

Two-entry elastic pipeline register that replaces a bare `_dff` wherever a CPU pipeline boundary needs valid/ready flow control. It accepts words from an upstream producer and presents them in order to a downstream consumer. Throughput is full (one word per cycle) and no combinational path runs between the two sides. It sits between pipeline stages, e.g. fetch→decode and decode→execute, and backpressure from a stalled stage propagates one register at a time.

## Interface
- `n`, default `WORD_LENGTH`: data width in bits.

- `clk` input 1: clock; all state updates on posedge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `flush` input 1: synchronous discard of all held words.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input n: upstream word.
- `out_valid` output 1: word presented downstream.
- `out_ready` input 1: downstream accepts the presented word.
- `out_data` output n: presented word (oldest held).
- `count` output 2: number of words held (0, 1 or 2).

## Operation
- Storage: main register (`main_d`, `main_v`) and skid register (`skid_d`, `skid_v`).
- Fire events:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- Output mapping: `out_valid = main_v`, `out_data = main_d`, `in_ready = ~skid_v`, `count = main_v + skid_v`. All are driven directly from registers.
- States (encoded by `{skid_v, main_v}`):
  - EMPTY (00):
    - `in_fire` → ONE, `main_d <= in_data`.
  - ONE (01):
    - `in_fire & ~out_fire` → FULL, `skid_d <= in_data`.
    - `in_fire & out_fire` → ONE, `main_d <= in_data`.
    - `~in_fire & out_fire` → EMPTY.
    - Neither → hold.
  - FULL (11), where `in_ready = 0`:
    - `out_fire` → ONE, `main_d <= skid_d`.
    - Otherwise hold.
  - State 10 is unreachable. If it is ever entered, the next edge goes to EMPTY.
- Ordering: strict FIFO. The word in skid is always younger than the word in main.
- `flush = 1` at an edge:
  - Next state is EMPTY regardless of handshakes.
  - A word offered in the same cycle is dropped.
  - A word consumed in the same cycle counts as delivered.
  - Data registers keep their old contents; they are don't-care while invalid.
- Upstream obligation: hold `in_valid`/`in_data` stable until `in_fire`. The block does not check this.
- Downstream guarantee: `out_data` is stable while `out_valid & ~out_ready`.
- `in_data` is sampled only on `in_fire`. `out_ready` is ignored when `out_valid = 0`.

## Timing
- Reset (`rst_n = 0`, asynchronous, immediate):
  - `main_v = skid_v = 0`, `main_d = skid_d = 0`.
  - Giving `out_valid = 0`, `out_data = 0`, `in_ready = 1`, `count = 0`.
- Reset release: the first accept can occur at the first posedge with `rst_n = 1`.
- Latency:
  - A word accepted at edge k is on `out_data` with `out_valid = 1` immediately after edge k.
  - It is consumed no earlier than edge k+1.
- Backpressure: `in_ready` falls one cycle after downstream stalls with one word held and a new word accepted (ONE→FULL). It rises immediately after the edge at which FULL drains.
- Sustained throughput: with `in_valid = out_ready = 1` continuously, one word per cycle and count stays at 1.
- Reset asserted mid-operation: held words are lost and the outputs take their reset values asynchronously, without waiting for a clock edge.
- Combinational paths: none from any input to any output.

## Test plan
- Reset, single word:
  - Stimulus: assert `rst_n = 0` mid-FULL, then release; send `in_data = 0xA5` with `out_ready = 0`.
  - Response: during reset, `count = 0`, `in_ready = 1`, `out_data = 0`. After the accept edge, `out_valid = 1`, `out_data = 0xA5`, `count = 1`.
- Fill and stall:
  - Stimulus: `out_ready = 0`, offer 1, 2, 3 on consecutive cycles.
  - Response: 1 and 2 accepted, `count = 2`, `in_ready = 0`. Word 3 is held by upstream; `out_data` stays 1.
- Drain order:
  - Stimulus: from FULL(1, 2), raise `out_ready`, keep offering 3.
  - Response: outputs 1, 2, 3 on successive cycles with no gaps. `in_ready` returns to 1 after the first drain edge.
- Streaming:
  - Stimulus: 100 consecutive words 0..99 with `in_valid = out_ready = 1`.
  - Response: 100 words out in order, one per cycle, `count` constant at 1 after the first edge.
- Random backpressure:
  - Stimulus: random `in_valid`/`out_ready` for 10k cycles.
  - Response: the scoreboard sees an exact FIFO match. `count` always equals (accepted − delivered) and never exceeds 2.
- Flush:
  - Stimulus: from FULL, assert `flush` with `in_valid = 1`, `out_ready = 1`.
  - Response: the head word counts as delivered and the offered word is dropped. Next cycle `count = 0`, `out_valid = 0`, `in_ready = 1`.
